// File: rtl/dac_channel_scheduler_pkg.sv
// Shared definitions for the DAC channel scheduler: FSM state codes,
// 24-bit DAC frame layout and default timing parameters.
package dac_channel_scheduler_pkg;

  // FSM state encoding kept as plain constants so older tools can read it
  typedef logic [2:0] sched_state_t;
  localparam sched_state_t ST_IDLE       = 3'd0;
  localparam sched_state_t ST_ISSUE      = 3'd1;
  localparam sched_state_t ST_WAIT_START = 3'd2;
  localparam sched_state_t ST_WAIT_END   = 3'd3;
  localparam sched_state_t ST_GAP        = 3'd4;

  // Default timing in clock_in cycles
  localparam int DEFAULT_GAP_CYCLES = 40;
  localparam int DEFAULT_WD_CYCLES  = 2048;

  // Frame field widths
  localparam int FRAME_W  = 24;
  localparam int SAMPLE_W = 16;
  localparam int CH_IDX_W = 2;

  // Frame field positions (LSB of each field)
  localparam int FRAME_PREFIX_LSB = 22;
  localparam int FRAME_CMD_LSB    = 20;
  localparam int FRAME_ADDR_LSB   = 18;
  localparam int FRAME_PAD_LSB    = 16;
  localparam int FRAME_DATA_LSB   = 0;

  // Fixed field contents: write-and-update command, zero prefix/pad bits
  localparam logic [1:0] FRAME_PREFIX   = 2'b00;
  localparam logic [1:0] FRAME_CMD_LOAD = 2'b01;
  localparam logic [1:0] FRAME_PAD      = 2'b00;

  // Assemble one DAC frame from a channel index and a sample
  function automatic logic [FRAME_W-1:0] make_frame(input logic [CH_IDX_W-1:0] ch,
                                                    input logic [SAMPLE_W-1:0] sample);
    logic [FRAME_W-1:0] f;
    f = '0;
    f[FRAME_PREFIX_LSB +: 2]        = FRAME_PREFIX;
    f[FRAME_CMD_LSB +: 2]           = FRAME_CMD_LOAD;
    f[FRAME_ADDR_LSB +: CH_IDX_W]   = ch;
    f[FRAME_PAD_LSB +: 2]           = FRAME_PAD;
    f[FRAME_DATA_LSB +: SAMPLE_W]   = sample;
    return f;
  endfunction

endpackage

// File: rtl/dac_rr_arbiter.sv
// Combinational round-robin arbiter: searches the pending vector starting
// at rr_ptr and returns the first pending channel index.
module dac_rr_arbiter
  import dac_channel_scheduler_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]   pending,
  input  logic [CH_IDX_W-1:0] rr_ptr,
  output logic [CH_IDX_W-1:0] grant_idx,
  output logic                grant_valid
);

  // Walk the channels in rotated order and take the first pending one
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      int cand;
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      for (int j = 0; j < NUM_CH; j++) begin
        if (!grant_valid && (j == cand) && pending[j]) begin
          grant_valid = 1'b1;
          grant_idx   = CH_IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/dac_channel_scheduler.sv
// DAC channel scheduler: holds the latest sample per channel, picks pending
// channels round-robin and hands one 24-bit frame at a time to the serializer,
// pacing frames by the serializer's chip-select and a post-frame gap.
// Optional watchdog on stuck frames is enabled by defining SCHED_WATCHDOG_EN.
module dac_channel_scheduler
  import dac_channel_scheduler_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES,
  parameter int WD_CYCLES  = DEFAULT_WD_CYCLES
) (
  input  logic                       clock_in,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          sample_strobe,
  input  logic [SAMPLE_W*NUM_CH-1:0] sample_data,
  input  logic                       spi_cs_in,
  output logic [FRAME_W-1:0]         dac_data,
  output logic                       dac_send,
  output logic                       busy,
  output logic [NUM_CH-1:0]          overrun,
  output logic                       wd_error
);

  localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

  // Reject channel counts the 2-bit address field cannot describe
  if (NUM_CH < 2 || NUM_CH > 4 || GAP_CYCLES < 1 || WD_CYCLES < 1) begin : g_cfg_check
    $error("dac_channel_scheduler: unsupported parameter set");
  end

  sched_state_t          state;
  logic [SAMPLE_W-1:0]   holding [NUM_CH];
  logic [NUM_CH-1:0]     pending;
  logic [CH_IDX_W-1:0]   rr_ptr;
  logic [CH_IDX_W-1:0]   grant_idx;
  logic                  grant_valid;
  logic                  grant_fire;
  logic [SAMPLE_W-1:0]   grant_sample;
  logic [GAP_W-1:0]      gap_cnt;
  logic [FRAME_W-1:0]    frame_q;
  logic                  wd_expire;

  dac_rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arbiter (
    .pending     (pending),
    .rr_ptr      (rr_ptr),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign grant_fire = (state == ST_IDLE) && grant_valid;

  // Select the held sample of the granted channel
  always_comb begin
    grant_sample = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (grant_idx == CH_IDX_W'(n)) grant_sample = holding[n];
    end
  end

  // Per-channel holding registers, pending and sticky overrun flags
  always_ff @(posedge clock_in) begin
    if (reset) begin
      pending <= '0;
      overrun <= '0;
      for (int n = 0; n < NUM_CH; n++) holding[n] <= '0;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (sample_strobe[n]) begin
          holding[n] <= sample_data[SAMPLE_W*n +: SAMPLE_W];
          pending[n] <= 1'b1;
          if (pending[n] && !(grant_fire && (grant_idx == CH_IDX_W'(n))))
            overrun[n] <= 1'b1;
        end else if (grant_fire && (grant_idx == CH_IDX_W'(n))) begin
          pending[n] <= 1'b0;
        end
      end
    end
  end

`ifdef SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_error_q;
  logic            in_wait;

  assign in_wait   = (state == ST_WAIT_START) || (state == ST_WAIT_END);
  assign wd_expire = in_wait && (wd_cnt == WD_W'(WD_CYCLES - 1));
  assign wd_error  = wd_error_q;

  // Count cycles spent waiting on the serializer; flag a frame that never ends
  always_ff @(posedge clock_in) begin
    if (reset) begin
      wd_cnt     <= '0;
      wd_error_q <= 1'b0;
    end else if (in_wait) begin
      if (wd_expire) begin
        wd_cnt     <= '0;
        wd_error_q <= 1'b1;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end else begin
      wd_cnt <= '0;
    end
  end
`else
  assign wd_expire = 1'b0;
  assign wd_error  = 1'b0;
`endif

  // Frame sequencing: grant, issue, follow chip-select, then enforce the gap
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state   <= ST_IDLE;
      gap_cnt <= '0;
      frame_q <= '0;
      rr_ptr  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_fire) begin
            frame_q <= make_frame(grant_idx, grant_sample);
            rr_ptr  <= (grant_idx == CH_IDX_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT_START;
        end
        ST_WAIT_START: begin
          if (wd_expire) begin
            state   <= ST_GAP;
            gap_cnt <= GAP_W'(GAP_CYCLES);
          end else if (!spi_cs_in) begin
            state <= ST_WAIT_END;
          end
        end
        ST_WAIT_END: begin
          if (wd_expire || spi_cs_in) begin
            state   <= ST_GAP;
            gap_cnt <= GAP_W'(GAP_CYCLES);
          end
        end
        ST_GAP: begin
          if (gap_cnt <= GAP_W'(1)) begin
            state   <= ST_IDLE;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dac_data = frame_q;
  assign dac_send = (state == ST_ISSUE);
  assign busy     = (state != ST_IDLE);

endmodule
